// File: rtl/uart_irq_ctrl_if.sv
// uart_irq_ctrl_if: register request/response bus for uart_irq_ctrl.
// The master issues valid/write/addr/wdata and holds them until ready;
// the slave answers with a one-cycle ready strobe carrying rdata/error.
interface uart_irq_ctrl_if #(
    parameter int unsigned AddrWidth = 8
);
    logic                 valid;
    logic                 write;
    logic [AddrWidth-1:0] addr;
    logic [31:0]          wdata;
    logic                 ready;
    logic [31:0]          rdata;
    logic                 error;

    modport master (
        output valid, write, addr, wdata,
        input  ready, rdata, error
    );

    modport slave (
        input  valid, write, addr, wdata,
        output ready, rdata, error
    );
endinterface

// File: rtl/uart_irq_ctrl.sv
// uart_irq_ctrl: latches per-channel UART interrupt sources into pending
// bits, masks them with per-source enables and drives one IRQ per channel
// plus a global IRQ. Registers are reached through uart_irq_ctrl_if.
// Channel c lives at c*0x20: 0x00 STATE (W1C), 0x04 ENABLE, 0x08 TEST
// (W1S, reads 0), 0x0C RAW (read-only).
// Define UART_IRQ_CTRL_COUNT_EN to add a 16-bit saturating event counter
// at offset 0x10 (any write clears it); without it 0x10 is an error.
module uart_irq_ctrl #(
    parameter int unsigned NumChannels = 2,
    parameter int unsigned AddrWidth   = 8,
    parameter logic [7:0]  EdgeMask    = 8'hFF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumChannels*8-1:0] intr_i,
    uart_irq_ctrl_if.slave           reg_bus,
    output logic [NumChannels-1:0]   irq_o,
    output logic                     irq_any_o
);
    localparam int unsigned MapBytes = NumChannels * 32;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t state;

    logic [NumChannels-1:0][7:0] intr;
    logic [NumChannels-1:0][7:0] pending;
    logic [NumChannels-1:0][7:0] enable;
    logic [NumChannels-1:0][7:0] prev;
    logic [NumChannels-1:0][7:0] set_vec;
    logic [NumChannels-1:0][7:0] clr_vec;
    logic [NumChannels-1:0][7:0] test_vec;
    logic [NumChannels-1:0][7:0] pending_nxt;
    logic [NumChannels-1:0]      sel;

    logic [31:0] addr;
    logic [4:0]  offset;
    logic [2:0]  chan;
    logic        in_range;
    logic        aligned;
    logic        off_state;
    logic        off_enable;
    logic        off_test;
    logic        off_raw;
    logic        off_count;
    logic        mapped;
    logic        err;
    logic        accept;
    logic        wr_ok;
    logic [31:0] rd_val;

    assign intr = intr_i;

    // Address decode; NumChannels <= 8 keeps every valid address below 0x100.
    assign addr       = 32'(reg_bus.addr);
    assign offset     = addr[4:0];
    assign chan       = addr[7:5];
    assign in_range   = addr < MapBytes;
    assign aligned    = addr[1:0] == 2'b00;
    assign off_state  = offset == 5'h00;
    assign off_enable = offset == 5'h04;
    assign off_test   = offset == 5'h08;
    assign off_raw    = offset == 5'h0C;
`ifdef UART_IRQ_CTRL_COUNT_EN
    assign off_count  = offset == 5'h10;
`else
    assign off_count  = 1'b0;
`endif
    assign mapped     = off_state | off_enable | off_test | off_raw | off_count;
    assign err        = !(in_range && aligned && mapped);
    assign accept     = (state == IDLE) && reg_bus.valid;
    assign wr_ok      = accept && reg_bus.write && !err;

    // One-hot channel select for the addressed register block.
    always_comb begin
        sel = '0;
        for (int unsigned c = 0; c < NumChannels; c++) begin
            sel[c] = in_range && (chan == 3'(c));
        end
    end

    // Next pending value: source sets and TEST sets win over a W1C.
    always_comb begin
        set_vec     = '0;
        clr_vec     = '0;
        test_vec    = '0;
        pending_nxt = '0;
        for (int unsigned c = 0; c < NumChannels; c++) begin
            test_vec[c]    = (wr_ok && sel[c] && off_test)  ? reg_bus.wdata[7:0] : '0;
            clr_vec[c]     = (wr_ok && sel[c] && off_state) ? reg_bus.wdata[7:0] : '0;
            set_vec[c]     = (intr[c] & ~prev[c] & EdgeMask)
                           | (intr[c] & ~EdgeMask)
                           | test_vec[c];
            pending_nxt[c] = (pending[c] & ~clr_vec[c]) | set_vec[c];
        end
    end

    // Pending, enable and previous-sample registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending <= '0;
            enable  <= '0;
            prev    <= '0;
        end else begin
            prev    <= intr;
            pending <= pending_nxt;
            for (int unsigned c = 0; c < NumChannels; c++) begin
                if (wr_ok && sel[c] && off_enable) begin
                    enable[c] <= reg_bus.wdata[7:0];
                end
            end
        end
    end

`ifdef UART_IRQ_CTRL_COUNT_EN
    logic [NumChannels-1:0][15:0] count;
    logic [NumChannels-1:0]       rise_any;

    // A channel counts one event per cycle in which any pending bit rises.
    always_comb begin
        rise_any = '0;
        for (int unsigned c = 0; c < NumChannels; c++) begin
            rise_any[c] = |(pending_nxt[c] & ~pending[c]);
        end
    end

    // Saturating counters; a write clears and beats a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= '0;
        end else begin
            for (int unsigned c = 0; c < NumChannels; c++) begin
                if (wr_ok && sel[c] && off_count) begin
                    count[c] <= '0;
                end else if (rise_any[c] && (count[c] != 16'hFFFF)) begin
                    count[c] <= count[c] + 16'd1;
                end
            end
        end
    end
`endif

    // Read mux; sampled before this edge's update, so STATE shows the old value.
    always_comb begin
        rd_val = '0;
        for (int unsigned c = 0; c < NumChannels; c++) begin
            if (sel[c]) begin
                if (off_state) begin
                    rd_val[7:0] = pending[c];
                end else if (off_enable) begin
                    rd_val[7:0] = enable[c];
                end else if (off_raw) begin
                    rd_val[7:0] = intr[c];
                end
`ifdef UART_IRQ_CTRL_COUNT_EN
                else if (off_count) begin
                    rd_val[15:0] = count[c];
                end
`endif
            end
        end
    end

    // Handshake FSM: accept in IDLE, present a one-cycle response in RESP.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            reg_bus.ready <= 1'b0;
            reg_bus.rdata <= '0;
            reg_bus.error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (reg_bus.valid) begin
                        state         <= RESP;
                        reg_bus.ready <= 1'b1;
                        reg_bus.rdata <= (err || reg_bus.write) ? '0 : rd_val;
                        reg_bus.error <= err;
                    end
                end
                RESP: begin
                    state         <= IDLE;
                    reg_bus.ready <= 1'b0;
                    reg_bus.rdata <= '0;
                    reg_bus.error <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Per-channel IRQ straight from the pending/enable flops.
    always_comb begin
        irq_o = '0;
        for (int unsigned c = 0; c < NumChannels; c++) begin
            irq_o[c] = |(pending[c] & enable[c]);
        end
    end

    assign irq_any_o = |irq_o;
endmodule

// File: tb/tb_uart_irq_ctrl.sv
// tb_uart_irq_ctrl: directed plus random stimulus against a per-bit
// behavioural model; expected responses go into a queue that a separate
// negedge monitor drains whenever the DUT strobes ready.
module tb_uart_irq_ctrl;
    localparam int unsigned NCH = 2;
    localparam logic [7:0]  EM  = 8'hF7;  // bit 3 level, all others edge
`ifdef UART_IRQ_CTRL_COUNT_EN
    localparam bit HAS_CNT = 1'b1;
`else
    localparam bit HAS_CNT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH*8-1:0] intr;
    logic [NCH-1:0]   irq;
    logic             irq_any;

    uart_irq_ctrl_if #(.AddrWidth(8)) bus ();

    uart_irq_ctrl #(
        .NumChannels(NCH),
        .AddrWidth  (8),
        .EdgeMask   (EM)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .intr_i   (intr),
        .reg_bus  (bus),
        .irq_o    (irq),
        .irq_any_o(irq_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned cyc;
    } resp_t;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    bit          m_rst_seen = 1'b0;
    logic [7:0]  m_pend [NCH];
    logic [7:0]  m_en   [NCH];
    logic [7:0]  m_prev [NCH];
    int unsigned m_cnt  [NCH];
    resp_t       exp_q  [$];

    // Reference model: one step per clock edge, applied bit by bit.
    task automatic model_step();
        int unsigned a, ch, off;
        bit          ok, wr;
        resp_t       r;
        logic [7:0]  cur, newp;
        bit          rose, setb, clrb, tstb;
        a   = int'(bus.addr);
        ch  = a / 32;
        off = a % 32;
        ok  = (a < NCH * 32) && (a % 4 == 0) &&
              (off <= 12 || (HAS_CNT && off == 16));
        wr  = bus.valid && bus.write && ok;
        if (bus.valid) begin
            r.err   = !ok;
            r.rdata = 32'h0;
            r.cyc   = cyc;
            if (ok && !bus.write) begin
                case (off)
                    0:  r.rdata = {24'h0, m_pend[ch]};
                    4:  r.rdata = {24'h0, m_en[ch]};
                    12: r.rdata = {24'h0, intr[ch*8 +: 8]};
                    16: r.rdata = m_cnt[ch];
                    default: r.rdata = 32'h0;
                endcase
            end
            exp_q.push_back(r);
        end
        for (int c = 0; c < NCH; c++) begin
            cur  = intr[c*8 +: 8];
            newp = m_pend[c];
            for (int b = 0; b < 8; b++) begin
                rose = cur[b] && !m_prev[c][b];
                setb = EM[b] ? rose : cur[b];
                tstb = wr && ch == c && off == 8 && bus.wdata[b];
                clrb = wr && ch == c && off == 0 && bus.wdata[b];
                if (setb || tstb) newp[b] = 1'b1;
                else if (clrb)    newp[b] = 1'b0;
            end
            if (HAS_CNT) begin
                if (wr && ch == c && off == 16)
                    m_cnt[c] = 0;
                else if ((newp & ~m_pend[c]) != 8'h00 && m_cnt[c] < 65535)
                    m_cnt[c] = m_cnt[c] + 1;
            end
            if (wr && ch == c && off == 4) m_en[c] = bus.wdata[7:0];
            m_pend[c] = newp;
            m_prev[c] = cur;
        end
    endtask

    // Advance the model at every active edge.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_pend[c] = 8'h00;
                m_en[c]   = 8'h00;
                m_prev[c] = 8'h00;
                m_cnt[c]  = 0;
            end
            m_rst_seen = 1'b1;
        end else begin
            model_step();
        end
    end

    // Monitor: IRQ lines every cycle, responses whenever ready is seen.
    always @(negedge clk) begin
        resp_t          e;
        logic [NCH-1:0] ei;
        if (m_rst_seen) begin
            m_rst_seen = 1'b0;
            total++;
            if (bus.ready !== 1'b0 || bus.rdata !== 32'h0 || bus.error !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs got ready=%b rdata=%h error=%b want 0/0/0",
                         bus.ready, bus.rdata, bus.error);
            end
        end
        for (int c = 0; c < NCH; c++) ei[c] = |(m_pend[c] & m_en[c]);
        total++;
        if (irq !== ei || irq_any !== |ei) begin
            bad++;
            $display("FAIL irq cyc=%0d got irq=%b any=%b want irq=%b any=%b",
                     cyc, irq, irq_any, ei, |ei);
        end
        if (bus.ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ready cyc=%0d got ready=1 want 0", cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.rdata !== e.rdata || bus.error !== e.err || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL resp cyc=%0d got rdata=%h err=%b want rdata=%h err=%b at cyc=%0d",
                             cyc, bus.rdata, bus.error, e.rdata, e.err, e.cyc);
                end
            end
        end else if (exp_q.size() != 0) begin
            total++;
            bad++;
            e = exp_q.pop_front();
            $display("FAIL missing_ready cyc=%0d got ready=%b want 1 (rdata=%h)",
                     cyc, bus.ready, e.rdata);
        end
    end

    task automatic access(input bit wr, input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.write = wr;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge clk);
        bus.valid = 1'b0;
        bus.write = 1'b0;
        bus.addr  = 8'h00;
        bus.wdata = 32'h0;
    endtask

    task automatic pulse(input int unsigned bitn);
        @(negedge clk);
        intr[bitn] = 1'b1;
        @(negedge clk);
        intr[bitn] = 1'b0;
    endtask

    initial begin
        logic [7:0] addrs [10];
        logic [7:0] a;
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20, 8'h24, 8'h28, 8'h2C, 8'h30};
        rst       = 1'b1;
        intr      = '0;
        bus.valid = 1'b0;
        bus.write = 1'b0;
        bus.addr  = 8'h00;
        bus.wdata = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Every register of both channels after reset.
        foreach (addrs[i]) access(1'b0, addrs[i], 32'h0);

        // Edge source on channel 1, enable, W1C.
        access(1'b1, 8'h24, 32'h01);
        pulse(8);
        access(1'b0, 8'h20, 32'h0);
        access(1'b1, 8'h20, 32'h01);
        access(1'b0, 8'h20, 32'h0);

        // Level source bit 3: set beats clear while held high.
        @(negedge clk) intr[3] = 1'b1;
        access(1'b1, 8'h00, 32'h08);
        access(1'b0, 8'h00, 32'h0);
        @(negedge clk) intr[3] = 1'b0;
        access(1'b1, 8'h00, 32'h08);
        access(1'b0, 8'h00, 32'h0);

        // TEST sets pending while masked, then unmask.
        access(1'b1, 8'h04, 32'h00);
        access(1'b1, 8'h08, 32'h80);
        access(1'b0, 8'h00, 32'h0);
        access(1'b0, 8'h08, 32'h0);
        access(1'b1, 8'h04, 32'h80);
        repeat (2) @(negedge clk);

        // Error cases must leave state untouched.
        access(1'b1, 8'h44, 32'hFF);
        access(1'b0, 8'h44, 32'h0);
        access(1'b1, 8'h06, 32'hFF);
        access(1'b0, 8'h06, 32'h0);
        access(1'b1, 8'h14, 32'hFF);
        access(1'b0, 8'h1C, 32'h0);
        access(1'b0, 8'h00, 32'h0);
        access(1'b0, 8'h04, 32'h0);
        access(1'b1, 8'h0C, 32'hFF);
        access(1'b0, 8'h00, 32'h0);

        // Reset arriving with a request aborts it and clears all state.
        access(1'b1, 8'h24, 32'hFF);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.write = 1'b1;
        bus.addr  = 8'h04;
        bus.wdata = 32'hFF;
        rst       = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        bus.valid = 1'b0;
        bus.write = 1'b0;
        access(1'b0, 8'h04, 32'h0);
        access(1'b0, 8'h24, 32'h0);
        access(1'b0, 8'h00, 32'h0);

        // Count-free builds must reject 0x10; count builds return the counter.
        access(1'b0, 8'h10, 32'h0);
        access(1'b0, 8'h30, 32'h0);
`ifdef UART_IRQ_CTRL_COUNT_EN
        for (int i = 0; i < 3; i++) begin
            pulse(5);
            access(1'b1, 8'h00, 32'h20);
        end
        access(1'b0, 8'h10, 32'h0);
        access(1'b1, 8'h10, 32'h0);
        access(1'b0, 8'h10, 32'h0);
        // Rising pending bit on every edge: 70000 events saturate the counter.
        @(negedge clk) intr = '0;
        access(1'b1, 8'h00, 32'hFF);
        access(1'b1, 8'h10, 32'h0);
        for (int i = 0; i < 17500; i++) begin
            @(negedge clk);
            bus.valid = 1'b1; bus.write = 1'b1; bus.addr = 8'h00; bus.wdata = 32'hFF;
            intr = 16'h0001;
            @(negedge clk);
            bus.valid = 1'b0;
            intr = 16'h0002;
            @(negedge clk);
            bus.valid = 1'b1;
            intr = 16'h0004;
            @(negedge clk);
            bus.valid = 1'b0;
            intr = 16'h0010;
        end
        @(negedge clk) intr = '0;
        bus.write = 1'b0;
        access(1'b0, 8'h10, 32'h0);
        access(1'b0, 8'h30, 32'h0);
`endif

        // Random phase: sparse source toggles mixed with random accesses.
        repeat (400) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                intr = intr ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            end
            if ($urandom_range(0, 9) < 8) begin
                a = 8'($urandom_range(0, NCH - 1) * 32 + $urandom_range(0, 4) * 4);
            end else begin
                a = 8'($urandom);
            end
            access(1'($urandom), a, $urandom);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
